// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one pipelined signed 16x16
// multiplier among NUM_REQ requesters.
//
// A grant is chosen combinationally from req_valid_i and the registered
// round-robin pointer. The granted requester's operands are presented on
// mul_a_o/mul_b_o. A tag pipeline the same length as the multiplier
// latency carries {valid, requester ID} alongside each operation, so the
// product can be returned on rsp_*_o one edge after it appears on mul_p_i.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid_i  [NUM_REQ]     per-requester operation request
//   req_a_i      [16*NUM_REQ]  signed operand A, requester i at [16i+15:16i]
//   req_b_i      [16*NUM_REQ]  signed operand B, same packing
//   req_ready_o  [NUM_REQ]     one-hot grant (accept = valid & ready)
//   mul_a_o      [16]          operand A to the shared multiplier
//   mul_b_o      [16]          operand B to the shared multiplier
//   mul_p_i      [32]          product from the multiplier (MULT_LAT edges later)
//   rsp_valid_o  1             one-cycle result strobe
//   rsp_id_o     [IDW]         requester owning rsp_p_o
//   rsp_p_o      [32]          signed product
//   inflight_o   [IDW+2]       accepted operations not yet returned
//   idle_o       1             no work in flight and no request pending
module mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 2,
  localparam int IDW     = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [16*NUM_REQ-1:0]  req_a_i,
  input  logic [16*NUM_REQ-1:0]  req_b_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [15:0]            mul_a_o,
  output logic [15:0]            mul_b_o,
  input  logic [31:0]            mul_p_i,
  output logic                   rsp_valid_o,
  output logic [IDW-1:0]         rsp_id_o,
  output logic [31:0]            rsp_p_o,
  output logic [IDW+1:0]         inflight_o,
  output logic                   idle_o
);

  localparam logic [IDW+1:0] INFL_ONE = {{(IDW+1){1'b0}}, 1'b1};

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  cand_s;
  logic            grant_found_s;
  logic [IDW-1:0]  grant_idx_s;
  logic            accept_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [15:0]     mul_a_s, mul_b_s;

  logic [MULT_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]      tag_id_q [MULT_LAT];

  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_p_q, rsp_p_d;
  logic [IDW+1:0]  inflight_q, inflight_d;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found_s && req_valid_i[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // The granted requester is valid by construction, so a grant is an acceptance.
  assign accept_s = grant_found_s;

  // One-hot ready and operand mux; everything zero when nobody is granted.
  always_comb begin
    req_ready_s = '0;
    mul_a_s     = 16'h0000;
    mul_b_s     = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_found_s && (grant_idx_s == IDW'(i))) begin
        req_ready_s[i] = 1'b1;
        mul_a_s        = req_a_i[16*i +: 16];
        mul_b_s        = req_b_i[16*i +: 16];
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  // Pointer moves to the slot after the accepted requester, wrapping at NUM_REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (!accept_s) begin
      ptr_d = ptr_q;
    end else if (grant_idx_s == IDW'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = grant_idx_s + IDW'(1);
    end
  end

  // Response capture: the last tag stage lines up with the product on mul_p_i.
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    if (tag_vld_q[MULT_LAT-1]) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = tag_id_q[MULT_LAT-1];
      rsp_p_d     = mul_p_i;
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // In-flight count; simultaneous accept and return cancel out.
  always_comb begin
    inflight_d = inflight_q;
    case ({accept_s, rsp_valid_q})
      2'b10:   inflight_d = inflight_q + INFL_ONE;
      2'b01:   inflight_d = inflight_q - INFL_ONE;
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers: pointer, tag pipeline, response and in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      for (int k = 0; k < MULT_LAT; k++) begin
        tag_id_q[k] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= 32'h0000_0000;
      inflight_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      tag_vld_q[0] <= accept_s;
      tag_id_q[0]  <= grant_idx_s;
      for (int k = 1; k < MULT_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      inflight_q  <= inflight_d;
    end
  end

  assign req_ready_o = req_ready_s;
  assign mul_a_o     = mul_a_s;
  assign mul_b_o     = mul_b_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_p_o     = rsp_p_q;
  assign inflight_o  = inflight_q;
  assign idle_o      = (inflight_q == '0) && (req_valid_i == '0);

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters sharing one multiplier (2..8).
REQ-002 Parameter MULT_LAT, default 2, meaning clock edges from operands at mul_a/mul_b to product at mul_p.
REQ-003 Derived IDW = max(1, clog2(NUM_REQ)), meaning requester-ID width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_a  input  16*NUM_REQ  signed operand A; requester i occupies bits [16i+15:16i].
REQ-008 req_b  input  16*NUM_REQ  signed operand B; same packing as req_a.
REQ-009 req_ready  output  NUM_REQ  one-hot grant; request accepted when req_valid[i] and req_ready[i] are both high in a cycle.
REQ-010 mul_a  output  16  signed operand to the shared multiplier.
REQ-011 mul_b  output  16  signed operand to the shared multiplier.
REQ-012 mul_p  input  32  signed product returned by the multiplier.
REQ-013 rsp_valid  output  1  one-cycle result strobe; no backpressure.
REQ-014 rsp_id  output  IDW  requester index owning rsp_p.
REQ-015 rsp_p  output  32  signed 32-bit product.
REQ-016 inflight  output  IDW+2  count of accepted operations not yet returned.
REQ-017 idle  output  1  high when inflight==0 and req_valid==0.

Function
REQ-018 Grant is combinational from req_valid and registered round-robin pointer ptr; the lowest index i >= ptr (cyclically) with req_valid[i]=1 is granted.
REQ-019 At most one req_ready bit high per cycle; req_ready is all-zero when req_valid is all-zero.
REQ-020 On acceptance of requester g, ptr updates to (g+1) mod NUM_REQ; without acceptance ptr holds.
REQ-021 mul_a/mul_b are combinational muxes of the granted requester's operands; both are 0 when nothing is granted.
REQ-022 A tag pipeline of MULT_LAT stages (valid bit + IDW-bit ID) is loaded each edge with {acceptance, granted index}; stage 0 is loaded with valid=0 when there is no acceptance.
REQ-023 When the last tag stage is valid, the next edge registers rsp_p<=mul_p, rsp_id<=tag ID, rsp_valid<=1; otherwise rsp_valid<=0 and rsp_p/rsp_id hold.
REQ-024 Latency: request accepted in cycle C -> rsp_valid high in cycle C+MULT_LAT+1 (C+3 at default); throughput one operation per cycle.
REQ-025 Results return in acceptance order; each accepted request yields exactly one rsp_valid pulse.
REQ-026 rsp_p is a pass-through of mul_p; no truncation, rounding or saturation.
REQ-027 inflight increments on acceptance, decrements on rsp_valid, and is unchanged when both occur in the same cycle.
REQ-028 A requester deasserting req_valid without being granted is legal; no state changes for that requester.
REQ-029 A requester holding req_valid high with the same operands is served again on its next turn; each grant is a new operation.

Reset
REQ-030 While rst_n is low: ptr=0, all tag stages invalid, rsp_valid=0, rsp_id=0, rsp_p=0, inflight=0; req_ready follows REQ-018 with ptr=0.
REQ-031 Reset asserted mid-operation discards all in-flight tags; no rsp_valid is produced for operations accepted before reset.
REQ-032 First grant after reset release goes to the lowest-index valid requester.

Verification
REQ-033 Single request: req 0, a=-3, b=7, accepted in cycle C -> rsp_valid at C+3, rsp_id=0, rsp_p=-21, inflight 1 then 0.
REQ-034 Extremes: a=-32768, b=-32768 -> rsp_p=1073741824; a=32767, b=-32768 -> rsp_p=-1073709056.
REQ-035 All four requesters valid continuously -> grants 0,1,2,3,0,... in back-to-back cycles; rsp_id sequence matches with no gaps.
REQ-036 Requesters 1 and 3 valid, ptr=2 -> grant 3 first, then 1; ptr ends at 2.
REQ-037 Accept three operations, assert rst_n low one cycle later -> no rsp_valid pulses, inflight=0, idle=1 after release.
REQ-038 Random 10k-cycle run with random req_valid/operands -> every rsp_p matches the signed reference product in order, and inflight never exceeds MULT_LAT+1.
